mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 23 ++
 rtl/mem_port_ctrl.sv | 71 +++++++
 rtl/mem_responder.sv | 97 +++++++++
 tb/tb_mem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and sizes for the dual-port memory responder.
package mem_responder_pkg;

  localparam int unsigned WAIT_CNT_W  = 4;
  localparam int unsigned DWORD_BYTES = 8;
  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned DATA_W      = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  // Request captured when a port leaves IDLE.
  typedef struct packed {
    logic                   wr;
    logic [ADDR_W-1:0]      addr;
    logic [DWORD_BYTES-1:0] mask;
    logic [DATA_W-1:0]      wdata;
  } port_req_t;

endpackage

// File: rtl/mem_port_ctrl.sv
// Per-port wait-state FSM: latches a request, counts wait cycles, aborts on
// a dropped or changed request, and strobes the array access.
module mem_port_ctrl
  import mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_rd,
  input  logic                   i_wr,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [DWORD_BYTES-1:0] i_mask,
  input  logic [DATA_W-1:0]      i_wdata,
  output port_req_t              o_req,
  output logic                   o_fire_c,
  output logic                   o_ready
);

  port_state_e           r_state;
  logic [WAIT_CNT_W-1:0] r_cnt;
  port_req_t             r_req;
  logic                  r_ready;

  logic w_req;
  logic w_match;

  // A simultaneous read and write is a write.
  assign w_req    = i_rd | i_wr;
  assign w_match  = w_req && (i_addr == r_req.addr) && (i_wr == r_req.wr);
  assign o_fire_c = (r_state == ST_WAIT) && w_match && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_req.wr    <= i_wr;
            r_req.addr  <= i_addr;
            r_req.mask  <= i_mask;
            r_req.wdata <= i_wdata;
            r_cnt       <= WAIT_CNT_W'(LATENCY);
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!w_match) begin
            r_state <= ST_IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WAIT_CNT_W'(1);
          end else begin
            r_state <= ST_RESP;
            r_ready <= 1'b1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req   = r_req;
  assign o_ready = r_ready;

endmodule

// File: rtl/mem_responder.sv
// Dual-port boot/program RAM: read-only fetch port and byte-masked data port
// over a shared doubleword array, each port with its own wait-state FSM.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2    = 12,
  parameter int unsigned INSTR_LATENCY = 1,
  parameter int unsigned DATA_LATENCY  = 2,
  parameter string       INIT_FILE     = ""
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      instr_address_in,
  input  logic                   instr_read_in,
  output logic [DATA_W-1:0]      instr_read_value_out,
  output logic                   instr_ready_out,
  input  logic [ADDR_W-1:0]      data_address_in,
  input  logic                   data_read_in,
  input  logic                   data_write_in,
  input  logic [DWORD_BYTES-1:0] data_write_mask_in,
  input  logic [DATA_W-1:0]      data_write_value_in,
  output logic [DATA_W-1:0]      data_read_value_out,
  output logic                   data_ready_out
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_instr_rdata;
  logic [DATA_W-1:0] r_data_rdata;

  port_req_t             w_i_req;
  port_req_t             w_d_req;
  logic                  w_i_fire;
  logic                  w_d_fire;
  logic [DEPTH_LOG2-1:0] w_i_idx;
  logic [DEPTH_LOG2-1:0] w_d_idx;
  logic                  w_unused;

  mem_port_ctrl #(.LATENCY(INSTR_LATENCY)) u_instr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rd     (instr_read_in),
    .i_wr     (1'b0),
    .i_addr   (instr_address_in),
    .i_mask   ('0),
    .i_wdata  ('0),
    .o_req    (w_i_req),
    .o_fire_c (w_i_fire),
    .o_ready  (instr_ready_out)
  );

  mem_port_ctrl #(.LATENCY(DATA_LATENCY)) u_data_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rd     (data_read_in),
    .i_wr     (data_write_in),
    .i_addr   (data_address_in),
    .i_mask   (data_write_mask_in),
    .i_wdata  (data_write_value_in),
    .o_req    (w_d_req),
    .o_fire_c (w_d_fire),
    .o_ready  (data_ready_out)
  );

  // Byte offset and bits above the array size are ignored, so addresses wrap.
  assign w_i_idx = w_i_req.addr[DEPTH_LOG2+2:3];
  assign w_d_idx = w_d_req.addr[DEPTH_LOG2+2:3];

  assign w_unused = ^{w_i_req.wr, w_i_req.mask, w_i_req.wdata,
                      w_i_req.addr[ADDR_W-1:DEPTH_LOG2+3], w_i_req.addr[2:0],
                      w_d_req.addr[ADDR_W-1:DEPTH_LOG2+3], w_d_req.addr[2:0]};

  // Masked store from the data port; array contents are never reset.
  always_ff @(posedge clk) begin
    if (w_d_fire && w_d_req.wr) begin
      for (int unsigned b = 0; b < DWORD_BYTES; b++) begin
        if (w_d_req.mask[b]) r_mem[w_d_idx][8*b +: 8] <= w_d_req.wdata[8*b +: 8];
      end
    end
  end

  // Read registers sample pre-write contents, giving read-before-write on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_rdata <= '0;
      r_data_rdata  <= '0;
    end else begin
      if (w_i_fire) r_instr_rdata <= r_mem[w_i_idx];
      if (w_d_fire && !w_d_req.wr) r_data_rdata <= r_mem[w_d_idx];
    end
  end

  assign instr_read_value_out = r_instr_rdata;
  assign data_read_value_out  = r_data_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table on the data port plus
// hand-written reset, abort, wrap and collision sequences.
module tb_mem_responder;

  localparam int unsigned DL   = 12;
  localparam int unsigned ILAT = 1;
  localparam int unsigned DLAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] instr_address_in = '0;
  logic        instr_read_in = 1'b0;
  logic [63:0] instr_read_value_out;
  logic        instr_ready_out;
  logic [63:0] data_address_in = '0;
  logic        data_read_in = 1'b0;
  logic        data_write_in = 1'b0;
  logic [7:0]  data_write_mask_in = '0;
  logic [63:0] data_write_value_in = '0;
  logic [63:0] data_read_value_out;
  logic        data_ready_out;

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH_LOG2(DL), .INSTR_LATENCY(ILAT), .DATA_LATENCY(DLAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_address_in(instr_address_in), .instr_read_in(instr_read_in),
    .instr_read_value_out(instr_read_value_out), .instr_ready_out(instr_ready_out),
    .data_address_in(data_address_in), .data_read_in(data_read_in),
    .data_write_in(data_write_in), .data_write_mask_in(data_write_mask_in),
    .data_write_value_in(data_write_value_in),
    .data_read_value_out(data_read_value_out), .data_ready_out(data_ready_out)
  );

  typedef struct {
    logic [63:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  mask;
    logic [63:0] wdata;
    logic [63:0] exp;
    string       name;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_rd = '0;
  vec_t        tbl[13];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for the data-port response already being driven; checks latency,
  // read value from the scoreboard and that ready is a single-cycle pulse.
  task automatic finish_data(input string name, input logic [63:0] exp);
    int          n;
    bit          got;
    logic [63:0] e;
    exp_q.push_back(exp);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk); got = data_ready_out;
    end
    data_read_in  = 1'b0;
    data_write_in = 1'b0;
    e = exp_q.pop_front();
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no data_ready_out within %0d cycles", name, n);
    end else begin
      check64({name, "_lat"}, 64'(n), 64'(DLAT + 2));
      check64({name, "_rdata"}, data_read_value_out, e);
    end
    @(posedge clk); @(negedge clk);
    check64({name, "_pulse"}, 64'(data_ready_out), 64'd0);
  endtask

  task automatic data_xfer(input logic [63:0] addr, input logic rd, input logic wr,
                           input logic [7:0] mask, input logic [63:0] wdata,
                           input logic [63:0] exp, input string name);
    data_address_in     = addr;
    data_read_in        = rd;
    data_write_in       = wr;
    data_write_mask_in  = mask;
    data_write_value_in = wdata;
    finish_data(name, exp);
    if (rd && !wr) last_rd = exp;
  endtask

  task automatic do_wr(input logic [63:0] addr, input logic [7:0] mask,
                       input logic [63:0] wdata, input string name);
    data_xfer(addr, 1'b0, 1'b1, mask, wdata, last_rd, name);
  endtask

  task automatic do_rd(input logic [63:0] addr, input logic [63:0] exp, input string name);
    data_xfer(addr, 1'b1, 1'b0, 8'h00, 64'h0, exp, name);
  endtask

  initial begin
    int          seen;
    int          n;
    bit          got;
    bit          i_done;
    bit          d_done;
    int          i_cyc;
    int          d_cyc;
    logic [63:0] i_val;

    tbl[0]  = '{64'h80,   1'b0, 1'b1, 8'hFF, 64'h0,                  64'h0,                  "clr80"};
    tbl[1]  = '{64'h80,   1'b0, 1'b1, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0,                  "wr80_m0f"};
    tbl[2]  = '{64'h80,   1'b1, 1'b0, 8'h00, 64'h0,                  64'h0000_0000_CCCC_DDDD, "rd80"};
    tbl[3]  = '{64'h8008, 1'b0, 1'b1, 8'hFF, 64'h5A5A,               64'h0000_0000_CCCC_DDDD, "wr8008"};
    tbl[4]  = '{64'h0008, 1'b1, 1'b0, 8'h00, 64'h0,                  64'h5A5A,               "rd0008_wrap"};
    tbl[5]  = '{64'h8009, 1'b1, 1'b0, 8'h00, 64'h0,                  64'h5A5A,               "rd8009"};
    tbl[6]  = '{64'h800F, 1'b1, 1'b0, 8'h00, 64'h0,                  64'h5A5A,               "rd800f"};
    tbl[7]  = '{64'h88,   1'b1, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h5A5A,               "rdwr88"};
    tbl[8]  = '{64'h88,   1'b1, 1'b0, 8'h00, 64'h0,                  64'h0123_4567_89AB_CDEF, "rd88"};
    tbl[9]  = '{64'h88,   1'b0, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, "wr88_m00"};
    tbl[10] = '{64'h88,   1'b1, 1'b0, 8'h00, 64'h0,                  64'h0123_4567_89AB_CDEF, "rd88_m00"};
    tbl[11] = '{64'h88,   1'b0, 1'b1, 8'h81, 64'hFF00_0000_0000_00EE, 64'h0123_4567_89AB_CDEF, "wr88_m81"};
    tbl[12] = '{64'h88,   1'b1, 1'b0, 8'h00, 64'h0,                  64'hFF23_4567_89AB_CDEE, "rd88_m81"};

    // Reset state
    @(negedge clk); @(negedge clk);
    check64("rst_instr_rdy", 64'(instr_ready_out), 64'd0);
    check64("rst_data_rdy", 64'(data_ready_out), 64'd0);
    check64("rst_instr_val", instr_read_value_out, 64'd0);
    check64("rst_data_val", data_read_value_out, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++)
      data_xfer(tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].mask, tbl[i].wdata, tbl[i].exp, tbl[i].name);

    // Fetch held across reset release sees ready only in its response cycle
    do_wr(64'h40, 8'hFF, 64'h1122_3344_5566_7788, "pre40");
    rst_n = 1'b0;
    #1;
    check64("rst2_data_val", data_read_value_out, 64'd0);
    last_rd = '0;
    instr_address_in = 64'h40;
    instr_read_in    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      check64($sformatf("fetch_rdy_c%0d", k), 64'(instr_ready_out), 64'(k == ILAT + 1));
      if (k == ILAT + 1) begin
        check64("fetch_val", instr_read_value_out, 64'h1122_3344_5566_7788);
        instr_read_in = 1'b0;
      end
    end

    // Abort: write dropped after one cycle, then address changed mid-WAIT
    do_wr(64'h100, 8'hFF, 64'h7777, "pre100");
    do_wr(64'h108, 8'hFF, 64'h8888, "pre108");
    data_address_in = 64'h100; data_write_in = 1'b1;
    data_write_mask_in = 8'hFF; data_write_value_in = 64'hDEAD;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) data_write_in = 1'b0;
      if (data_ready_out) seen++;
    end
    check64("abort_drop_noready", 64'(seen), 64'd0);
    do_rd(64'h100, 64'h7777, "abort_drop_mem");
    data_address_in = 64'h100; data_write_in = 1'b1;
    data_write_mask_in = 8'hFF; data_write_value_in = 64'hDEAD;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) data_address_in = 64'h108;
      if (k == 1) data_write_in = 1'b0;
      if (data_ready_out) seen++;
    end
    check64("abort_addr_noready", 64'(seen), 64'd0);
    do_rd(64'h100, 64'h7777, "abort_addr_mem100");
    do_rd(64'h108, 64'h8888, "abort_addr_mem108");

    // Collision: instr read and data write access index 0x40 on the same edge
    do_wr(64'h200, 8'hFF, 64'h1234, "pre200");
    data_address_in = 64'h200; data_write_in = 1'b1;
    data_write_mask_in = 8'hFF; data_write_value_in = '1;
    @(posedge clk); @(negedge clk);
    instr_address_in = 64'h200; instr_read_in = 1'b1;
    i_done = 1'b0; d_done = 1'b0; i_cyc = -1; d_cyc = -2; i_val = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (instr_ready_out && !i_done) begin
        i_done = 1'b1; i_cyc = k; i_val = instr_read_value_out; instr_read_in = 1'b0;
      end
      if (data_ready_out && !d_done) begin
        d_done = 1'b1; d_cyc = k; data_write_in = 1'b0;
      end
    end
    check64("coll_both_done", 64'({i_done, d_done}), 64'd3);
    check64("coll_same_cycle", 64'(i_cyc), 64'(d_cyc));
    check64("coll_instr_old", i_val, 64'h1234);
    do_rd(64'h200, 64'hFFFF_FFFF_FFFF_FFFF, "coll_after");

    // Async reset during WAIT of a write: aborted, then restarted when held
    do_wr(64'h300, 8'hFF, 64'h3333, "pre300");
    do_rd(64'h300, 64'h3333, "rd300");
    data_address_in = 64'h300; data_write_in = 1'b1;
    data_write_mask_in = 8'hFF; data_write_value_in = 64'h0BAD;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check64("rstw_rdy", 64'(data_ready_out), 64'd0);
    check64("rstw_val", data_read_value_out, 64'd0);
    last_rd = '0;
    data_write_in = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_rd(64'h300, 64'h3333, "rstw_mem");
    data_address_in = 64'h300; data_write_in = 1'b1;
    data_write_mask_in = 8'hFF; data_write_value_in = 64'h0BAD;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    finish_data("rstw_restart", last_rd);
    do_rd(64'h300, 64'h0BAD, "rstw_restart_mem");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
